rr_arb4_enc: RTL and testbench
==============================

# rr_arb4_enc

Four-requester round-robin arbiter producing an encoded 2-bit grant index plus a valid flag. It sits directly upstream of the 2-to-4 decoder stage: `gnt_idx` drives the decoder select, and `gnt_valid` gates its enable, so the decoder output becomes the one-hot grant bus. Grants are held until released, bounded by a hold timeout, and separated by a mandatory dead cycle.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive cycles one grant may stay valid; 0 disables the timeout.
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req`  in  4  request per requester, level-sensitive, bit i = requester i
- `done`  in  1  release pulse from the current owner; ignored when no grant is active
- `gnt_valid`  out  1  grant active; enable for the downstream decoder
- `gnt_idx`  out  2  index of the granted requester; holds last value while idle
- `busy`  out  1  high in GRANT state (equals `gnt_valid`, exported for status)

## Operation
- States: IDLE and GRANT.
- **IDLE:** if `req != 0`, pick the first set bit scanning upward from `ptr`, wrapping 3→0. At the edge, load `gnt_idx` with that bit, set `gnt_valid=1`, clear `hold_cnt`, and go to GRANT. If `req == 0`, stay in IDLE.
- **GRANT:** release at the edge when any of these is true:
  - `done=1`
  - `req[gnt_idx]=0`
  - `HOLD_MAX != 0` and `hold_cnt == HOLD_MAX-1`
- **On release:**
  - go to IDLE and set `gnt_valid=0`.
  - set `ptr = gnt_idx+1` (mod 4).
  - `gnt_idx` keeps its value.
- **Hold counter:** otherwise `hold_cnt` increments each cycle in GRANT. Its width is `$clog2(HOLD_MAX+1)`, minimum 1. It never wraps, because release occurs first.
- **Simultaneous release conditions:** any combination of `done`, request drop and timeout in the same cycle produces one release and one pointer advance.
- `done` sampled in IDLE has no effect.
- Requests arriving or dropping during GRANT for other indices do not affect the current grant.
- **Reset:** when `rst_n=0` at an edge, regardless of state:
  - state = IDLE
  - `gnt_valid=0`, `busy=0`, `gnt_idx=0`
  - `ptr=0`, `hold_cnt=0`
  - This includes reset mid-grant; the grant is dropped with no dead-cycle requirement beyond reset itself.

## Timing
- **Grant latency:** `req` sampled at edge N gives `gnt_valid=1` with a valid `gnt_idx` after edge N. That is 1 cycle, registered outputs only.
- **Release:** a condition sampled at edge K gives `gnt_valid=0` after edge K.
- **Dead cycle:** the earliest next grant is after edge K+1. There is always at least one `gnt_valid=0` cycle between grants, so downstream one-hot outputs never overlap or glitch between owners.
- **Timeout:** with `HOLD_MAX=H>0`, `gnt_valid` stays high for at most H consecutive cycles.
- **Throughput:** with all four requesting continuously and H=1, grants are 0,1,2,3,0… with one grant every 2 cycles.
- **Index stability:** `gnt_idx` changes only on the edge that sets `gnt_valid`; it is stable throughout a grant.

## Structure
- **Package `arb_pkg`:**
  - `N_REQ=4`, `IDX_W=2`
  - state enum `arb_state_t {IDLE, GRANT}`
- **Sub-module `rr_pick4`:** purely combinational.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `any`, `idx[1:0]`.
  - Implements the rotate / priority-encode / un-rotate.
  - It is instantiated once; the FSM, pointer and hold counter live in the top.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles with `req=4'b1111` → `gnt_valid=0`, `gnt_idx=0`, `busy=0` throughout. After release, the first grant is index 0 one cycle later.
- **Single requester:** `req=4'b0100`, `done` pulse 5 cycles after grant.
  - `gnt_idx=2`, `gnt_valid` high 5 cycles.
  - One dead cycle, then re-grant to 2 while `req[2]` stays high.
- **Fairness:** `req=4'b1111` held, `done` pulsed 1 cycle after each grant.
  - Grant order 0,1,2,3,0,1.
  - `gnt_valid` low exactly 1 cycle between each grant.
- **Timeout:** `HOLD_MAX=4`, `req=4'b0011`, no `done`.
  - Index 0 valid for exactly 4 cycles, one dead cycle, then index 1 for 4 cycles, then index 0.
  - `HOLD_MAX=0` variant: index 0 held indefinitely (≥100 cycles).
- **Request drop with simultaneous conditions:** grant to 3, then in one cycle deassert `req[3]` and pulse `done`.
  - Single release, `ptr` advances once.
  - With `req=4'b1001` the next grant is 0.
- **Reset mid-grant:** `rst_n=0` for one cycle during a grant to index 2.
  - `gnt_valid=0` and `gnt_idx=0` after that edge.
  - With `req=4'b0100` still asserted, the grant returns to 2 one cycle after reset deasserts.

Source files
------------

// File: rtl/rr_arb4_enc_pkg.sv
// Shared constants and state type for the four-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arb4_enc_pick.sv
// Round-robin pick: rotate requests so ptr sits at bit 0, take the lowest set
// bit, then rotate the found offset back into absolute requester numbering.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Rotate, priority-encode from the pointer upward, un-rotate.
  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N_REQ];
    off = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rot[i-1]) off = IDX_W'(i - 1);
    end
    any = |req;
    idx = off + ptr;
  end

endmodule

// File: rtl/rr_arb4_enc.sv
// Four-requester round-robin arbiter with encoded grant index, hold timeout
// and a mandatory dead cycle between grants.
module rr_arb4_enc
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy
);

  localparam int unsigned CNT_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             timeout;
  logic             rel;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign timeout   = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST);
  assign rel       = done || !req[gnt_idx] || timeout;
  assign gnt_valid = (state == GRANT);
  assign busy      = (state == GRANT);

  // Next-state, next index, pointer advance and hold counter.
  always_comb begin
    state_nxt = state;
    idx_nxt   = gnt_idx;
    ptr_nxt   = ptr;
    cnt_nxt   = hold_cnt;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          idx_nxt   = pick_idx;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_nxt = IDLE;
          ptr_nxt   = gnt_idx + IDX_W'(1);
        end else if (HOLD_MAX != 0) begin
          cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant index, pointer and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt_idx  <= idx_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arb4_enc.sv
// Bench for rr_arb4_enc: three instances (HOLD_MAX 15, 4, 0) share stimulus
// and are checked each cycle against a behavioural model, plus literal pins.
module tb_rr_arb4_enc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;

  logic       v15, v4, v0, b15, b4, b0;
  logic [1:0] i15, i4, i0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arb4_enc u15 (.clk(clk), .rst_n(rst_n), .req(req), .done(done),
                   .gnt_valid(v15), .gnt_idx(i15), .busy(b15));
  rr_arb4_enc #(.HOLD_MAX(4)) u4 (.clk(clk), .rst_n(rst_n), .req(req), .done(done),
                   .gnt_valid(v4), .gnt_idx(i4), .busy(b4));
  rr_arb4_enc #(.HOLD_MAX(0)) u0 (.clk(clk), .rst_n(rst_n), .req(req), .done(done),
                   .gnt_valid(v0), .gnt_idx(i0), .busy(b0));

  // Behavioural model: owner flag, owner index, next-start pointer, cycles held.
  int unsigned hmax [3] = '{15, 4, 0};
  bit          m_own  [3];
  int unsigned m_idx  [3];
  int unsigned m_ptr  [3];
  int unsigned m_held [3];
  bit          started = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_own[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_held[k] = 0;
      end else if (m_own[k]) begin
        if (done || !req[m_idx[k]] || (hmax[k] != 0 && m_held[k] >= hmax[k])) begin
          m_own[k] = 0;
          m_ptr[k] = (m_idx[k] + 1) % 4;
        end else begin
          m_held[k]++;
        end
      end else if (req != 0) begin
        for (int j = 0; j < 4; j++) begin
          if (!m_own[k] && req[(m_ptr[k] + j) % 4]) begin
            m_own[k]  = 1;
            m_idx[k]  = (m_ptr[k] + j) % 4;
            m_held[k] = 1;
          end
        end
      end
    end
    started = 1;
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (started) begin
      logic       dv [3];
      logic [1:0] di [3];
      logic       db [3];
      dv = '{v15, v4, v0};
      di = '{i15, i4, i0};
      db = '{b15, b4, b0};
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dv[k] !== m_own[k] || db[k] !== m_own[k] || di[k] !== m_idx[k][1:0]) begin
          errors++;
          $display("FAIL model[H=%0d] t=%0t: valid=%b busy=%b idx=%0d, required valid=%0d busy=%0d idx=%0d",
                   hmax[k], $time, dv[k], db[k], di[k], m_own[k], m_own[k], m_idx[k]);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d, required %0d", name, $time, got, exp);
    end
  endtask

  // Apply inputs, then wait to the falling edge after the sampling edge.
  task automatic drive(input logic [3:0] r, input logic d, input logic rn);
    req = r; done = d; rst_n = rn;
    @(negedge clk);
  endtask

  initial begin
    int exp_v4 [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    int exp_i4 [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    int order  [5]  = '{1, 2, 3, 0, 1};

    // Reset held with all requesting, then fairness with done one cycle in.
    for (int n = 0; n < 3; n++) begin
      drive(4'b1111, 1'b0, 1'b0);
      chk("reset_valid", v15, 0);
      chk("reset_idx", i15, 0);
      chk("reset_busy", b15, 0);
      chk("reset_valid_h4", v4, 0);
    end
    drive(4'b1111, 1'b0, 1'b1);
    chk("first_grant_valid", v15, 1);
    chk("first_grant_idx", i15, 0);
    for (int n = 0; n < 5; n++) begin
      drive(4'b1111, 1'b1, 1'b1);
      chk("fair_dead", v15, 0);
      drive(4'b1111, 1'b0, 1'b1);
      chk("fair_valid", v15, 1);
      chk("fair_idx", i15, order[n]);
    end

    // Single requester 2, done after five valid cycles.
    drive(4'b0100, 1'b0, 1'b0);
    drive(4'b0100, 1'b0, 1'b1);
    chk("single_idx", i15, 2);
    for (int n = 0; n < 4; n++) begin
      drive(4'b0100, 1'b0, 1'b1);
      chk("single_hold", v15, 1);
    end
    drive(4'b0100, 1'b1, 1'b1);
    chk("single_dead", v15, 0);
    drive(4'b0100, 1'b0, 1'b1);
    chk("single_regrant_valid", v15, 1);
    chk("single_regrant_idx", i15, 2);

    // Timeout with H=4 alternates 0/1; H=0 holds index 0 indefinitely.
    drive(4'b0011, 1'b0, 1'b0);
    for (int n = 0; n < 110; n++) begin
      drive(4'b0011, 1'b0, 1'b1);
      if (n < 11) begin
        chk("timeout_h4_valid", v4, exp_v4[n]);
        chk("timeout_h4_idx", i4, exp_i4[n]);
      end
      if (n == 0 || n == 109) begin
        chk("nolimit_h0_valid", v0, 1);
        chk("nolimit_h0_idx", i0, 0);
      end
    end

    // Grant to 3, drop req[3] together with done: pointer advances once.
    drive(4'b1000, 1'b0, 1'b0);
    drive(4'b1000, 1'b0, 1'b1);
    chk("drop_grant_idx", i15, 3);
    drive(4'b0000, 1'b1, 1'b1);
    chk("drop_dead", v15, 0);
    drive(4'b1001, 1'b0, 1'b1);
    chk("drop_next_valid", v15, 1);
    chk("drop_next_idx", i15, 0);

    // Reset during a grant to 2.
    drive(4'b0000, 1'b0, 1'b0);
    drive(4'b0100, 1'b0, 1'b1);
    chk("midrst_grant_idx", i15, 2);
    drive(4'b0100, 1'b0, 1'b0);
    chk("midrst_valid", v15, 0);
    chk("midrst_idx", i15, 0);
    drive(4'b0100, 1'b0, 1'b1);
    chk("midrst_regrant_valid", v15, 1);
    chk("midrst_regrant_idx", i15, 2);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] r;
      r = 4'($urandom);
      if ($urandom_range(3) == 0) r = 4'b1111;
      drive(r, ($urandom_range(4) == 0), ($urandom_range(63) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
